frame_pixel_writer: RTL and testbench

//  Receiving end of the pixel transfer stream. Accepts 12-bit RGB444 pixels qualified by strobe,

---
 rtl/frame_pixel_writer_pkg.sv | 23 ++
 rtl/frame_pixel_writer_fifo.sv | 53 +++++
 rtl/frame_pixel_writer.sv | 144 ++++++++++++++
 tb/tb_frame_pixel_writer.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/frame_pixel_writer_pkg.sv
// Shared constants for the frame pixel writer: default geometry, counter width and FSM encodings.
package frame_pixel_writer_pkg;

    localparam int PIX_W_DEF      = 12;
    localparam int ROWS_DEF       = 240;
    localparam int COLS_DEF       = 320;
    localparam int ROW_W_DEF      = 8;
    localparam int COL_W_DEF      = 9;
    localparam int FIFO_DEPTH_DEF = 4;

    // Wide enough to count a full 320x240 frame.
    localparam int CNT_W = 17;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RECV  = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    function automatic logic state_is_busy(input logic [1:0] st);
        return (st == ST_RECV) || (st == ST_DRAIN);
    endfunction

endpackage

// File: rtl/frame_pixel_writer_fifo.sv
// Small show-ahead pixel FIFO that soaks up frame-memory stalls; flush empties it in one cycle.
module frame_pixel_writer_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 12
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             flush_i,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [WIDTH-1:0] data_i,
    output logic [WIDTH-1:0] data_o,
    output logic             full_o,
    output logic             empty_o
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [AW:0]      count_q;

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_i) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop_i)  rd_ptr_q <= rd_ptr_q + AW'(1);
            case ({push_i, pop_i})
                2'b10:   count_q <= count_q + (AW + 1)'(1);
                2'b01:   count_q <= count_q - (AW + 1)'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (push_i && !flush_i) mem_q[wr_ptr_q] <= data_i;
    end

    assign data_o  = mem_q[rd_ptr_q];
    assign full_o  = (count_q == FULL_CNT);
    assign empty_o = (count_q == '0);

endmodule

// File: rtl/frame_pixel_writer.sv
// Receives a strobed RGB444 pixel stream, tags pixels with raster row/col and writes them to
// frame memory through a ready handshake, reporting frame completion, overflow and framing errors.
module frame_pixel_writer
    import frame_pixel_writer_pkg::*;
#(
    parameter int PIX_W      = PIX_W_DEF,
    parameter int ROWS       = ROWS_DEF,
    parameter int COLS       = COLS_DEF,
    parameter int ROW_W      = ROW_W_DEF,
    parameter int COL_W      = COL_W_DEF,
    parameter int FIFO_DEPTH = FIFO_DEPTH_DEF
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             sof_i,
    input  logic [PIX_W-1:0] pixel_i,
    input  logic             strobe_i,
    input  logic             mem_ready_i,
    output logic             wr_en_o,
    output logic [PIX_W-1:0] wr_data_o,
    output logic [ROW_W-1:0] wr_row_o,
    output logic [COL_W-1:0] wr_col_o,
    output logic             busy_o,
    output logic             frame_done_o,
    output logic             overflow_o,
    output logic             sync_err_o
);
    localparam logic [CNT_W-1:0] LAST_PIX = CNT_W'(ROWS * COLS - 1);
    localparam logic [COL_W-1:0] COL_LAST = COL_W'(COLS - 1);

    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] accept_q;
    logic [ROW_W-1:0] row_q, row_d;
    logic [COL_W-1:0] col_q, col_d;
    logic             out_valid_q;
    logic [PIX_W-1:0] out_data_q;
    logic [ROW_W-1:0] out_row_q;
    logic [COL_W-1:0] out_col_q;
    logic             overflow_q;
    logic             sync_err_q;

    logic             fifo_full, fifo_empty;
    logic [PIX_W-1:0] fifo_data;
    logic             push_req, push, pop, drop, stray;

    // A strobe in the same cycle as sof belongs to neither frame and is simply ignored.
    assign push_req = strobe_i && !sof_i && (state_q == ST_RECV);
    assign stray    = strobe_i && !sof_i && (state_q != ST_RECV);
    assign pop      = !sof_i && !fifo_empty && (!out_valid_q || mem_ready_i);
    assign push     = push_req && (!fifo_full || pop);
    assign drop     = push_req && fifo_full && !pop;

    frame_pixel_writer_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (PIX_W)
    ) u_pixel_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .flush_i (sof_i),
        .push_i  (push),
        .pop_i   (pop),
        .data_i  (pixel_i),
        .data_o  (fifo_data),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    always_comb begin
        state_d = state_q;
        if (sof_i) begin
            state_d = ST_RECV;
        end else begin
            case (state_q)
                ST_IDLE:  state_d = ST_IDLE;
                ST_RECV:  if (push_req && accept_q == LAST_PIX) state_d = ST_DRAIN;
                ST_DRAIN: if (fifo_empty && !out_valid_q) state_d = ST_DONE;
                ST_DONE:  state_d = ST_IDLE;
                default:  state_d = ST_IDLE;
            endcase
        end
    end

    // Raster address of the next pixel loaded into the output register.
    always_comb begin
        row_d = row_q;
        col_d = col_q;
        if (col_q == COL_LAST) begin
            col_d = '0;
            row_d = row_q + ROW_W'(1);
        end else begin
            col_d = col_q + COL_W'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= ST_IDLE;
            accept_q    <= '0;
            row_q       <= '0;
            col_q       <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_row_q   <= '0;
            out_col_q   <= '0;
            overflow_q  <= 1'b0;
            sync_err_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            if (sof_i) begin
                accept_q    <= '0;
                row_q       <= '0;
                col_q       <= '0;
                out_valid_q <= 1'b0;
                overflow_q  <= 1'b0;
                sync_err_q  <= 1'b0;
            end else begin
                // Dropped pixels still count so the frame length stays fixed.
                if (push_req) accept_q <= accept_q + CNT_W'(1);
                if (drop)     overflow_q <= 1'b1;
                if (stray)    sync_err_q <= 1'b1;
                if (pop) begin
                    out_valid_q <= 1'b1;
                    out_data_q  <= fifo_data;
                    out_row_q   <= row_q;
                    out_col_q   <= col_q;
                    row_q       <= row_d;
                    col_q       <= col_d;
                end else if (mem_ready_i) begin
                    out_valid_q <= 1'b0;
                end
            end
        end
    end

    assign wr_en_o      = out_valid_q;
    assign wr_data_o    = out_data_q;
    assign wr_row_o     = out_row_q;
    assign wr_col_o     = out_col_q;
    assign busy_o       = state_is_busy(state_q);
    assign frame_done_o = (state_q == ST_DONE);
    assign overflow_o   = overflow_q;
    assign sync_err_o   = sync_err_q;

endmodule

// File: tb/tb_frame_pixel_writer.sv
// Randomised bench for frame_pixel_writer on a 4x5 frame, checked cycle by cycle against a
// queue-based model of the pixel path and frame phases.
module tb_frame_pixel_writer;

    localparam int ROWS  = 4;
    localparam int COLS  = 5;
    localparam int DEPTH = 4;
    localparam int TOTAL = ROWS * COLS;

    logic        clk;
    logic        rst_n;
    logic        sof;
    logic [11:0] pix;
    logic        strobe;
    logic        mem_ready;
    logic        wr_en;
    logic [11:0] wr_data;
    logic [7:0]  wr_row;
    logic [8:0]  wr_col;
    logic        busy;
    logic        frame_done;
    logic        overflow;
    logic        sync_err;

    frame_pixel_writer #(
        .PIX_W      (12),
        .ROWS       (ROWS),
        .COLS       (COLS),
        .ROW_W      (8),
        .COL_W      (9),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .sof_i        (sof),
        .pixel_i      (pix),
        .strobe_i     (strobe),
        .mem_ready_i  (mem_ready),
        .wr_en_o      (wr_en),
        .wr_data_o    (wr_data),
        .wr_row_o     (wr_row),
        .wr_col_o     (wr_col),
        .busy_o       (busy),
        .frame_done_o (frame_done),
        .overflow_o   (overflow),
        .sync_err_o   (sync_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model: phase 0 idle, 1 receiving, 2 draining, 3 done.
    int  m_q[$];
    bit  m_have;
    int  m_pix, m_row, m_col;
    int  m_loads, m_acc, m_drops, m_phase;
    bit  m_ovf, m_serr;

    int  n_tests, n_fail;
    int  n_writes, n_done;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_q.delete();
        m_have  = 0;
        m_loads = 0;
        m_acc   = 0;
        m_drops = 0;
        m_phase = 0;
        m_ovf   = 0;
        m_serr  = 0;
    endtask

    task automatic model_step();
        bit was_empty, had_out, take, keep;
        int next_phase;
        was_empty  = (m_q.size() == 0);
        had_out    = m_have;
        next_phase = m_phase;
        keep       = 0;
        if (sof) begin
            model_reset();
            m_phase = 1;
            return;
        end
        take = !was_empty && (!m_have || mem_ready);
        if (strobe) begin
            if (m_phase == 1) begin
                if (m_q.size() < DEPTH || take) keep = 1;
                else begin
                    m_ovf = 1;
                    m_drops++;
                end
                m_acc++;
                if (m_acc == TOTAL) next_phase = 2;
            end else begin
                m_serr = 1;
            end
        end
        if (take) begin
            m_pix  = m_q.pop_front();
            m_row  = m_loads / COLS;
            m_col  = m_loads % COLS;
            m_loads++;
            m_have = 1;
        end else if (mem_ready) begin
            m_have = 0;
        end
        if (keep) m_q.push_back(int'(pix));
        if (m_phase == 3) next_phase = 0;
        else if (m_phase == 2 && was_empty && !had_out) next_phase = 3;
        m_phase = next_phase;
    endtask

    task automatic compare_all();
        check("wr_en", wr_en, m_have);
        if (m_have) begin
            check("wr_data", wr_data, m_pix);
            check("wr_row", wr_row, m_row);
            check("wr_col", wr_col, m_col);
        end
        check("busy", busy, (m_phase == 1 || m_phase == 2));
        check("frame_done", frame_done, (m_phase == 3));
        check("overflow", overflow, m_ovf);
        check("sync_err", sync_err, m_serr);
        if (frame_done) n_done++;
    endtask

    task automatic step(input bit s, input bit st, input logic [11:0] p, input bit mr);
        sof       = s;
        strobe    = st;
        pix       = p;
        mem_ready = mr;
        if (wr_en && mem_ready) n_writes++;
        model_step();
        @(posedge clk);
        #1;
        compare_all();
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_wr_en"}, wr_en, 0);
        check({tag, "_wr_data"}, wr_data, 0);
        check({tag, "_wr_row"}, wr_row, 0);
        check({tag, "_wr_col"}, wr_col, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_frame_done"}, frame_done, 0);
        check({tag, "_overflow"}, overflow, 0);
        check({tag, "_sync_err"}, sync_err, 0);
    endtask

    function automatic logic [11:0] rnd_pix();
        return 12'($urandom_range(0, 4095));
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc;
        n_tests = 0;
        n_fail  = 0;
        rst_n = 1'b0;
        sof = 0; strobe = 0; pix = '0; mem_ready = 0;
        model_reset();
        #1;
        check_all_zero("reset");
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Back-to-back frame with memory always ready.
        n_writes = 0; n_done = 0;
        step(1, 0, '0, 1);
        for (int i = 0; i < TOTAL; i++) step(0, 1, rnd_pix(), 1);
        for (int i = 0; i < 8; i++) step(0, 0, '0, 1);
        check("t1_writes", n_writes, TOTAL);
        check("t1_done", n_done, 1);

        // Backpressure: only output register plus FIFO depth survive.
        n_writes = 0; n_done = 0;
        step(1, 0, '0, 0);
        for (int i = 0; i < 10; i++) step(0, 1, rnd_pix(), 0);
        check("t2_ovf", overflow, 1);
        for (int i = 0; i < 8; i++) step(0, 0, '0, 1);
        check("t2_kept", n_writes, DEPTH + 1);
        for (int i = 0; i < 10; i++) step(0, 1, rnd_pix(), 1);
        for (int i = 0; i < 8; i++) step(0, 0, '0, 1);
        check("t2_writes", n_writes, TOTAL - 5);
        check("t2_done", n_done, 1);

        // Random strobes and random memory readiness, frame after frame.
        for (int f = 0; f < 25; f++) begin
            n_writes = 0; n_done = 0;
            step(1, 0, '0, ($urandom_range(0, 3) != 0));
            cyc = 0;
            while (m_phase != 0 && cyc < 400) begin
                step(0, ($urandom_range(0, 9) < 7), rnd_pix(), ($urandom_range(0, 3) != 0));
                cyc++;
            end
            check("t3_idle", busy, 0);
            check("t3_writes", n_writes, TOTAL - m_drops);
            check("t3_done", n_done, 1);
        end

        // Abort after 7 pixels, then a clean frame.
        n_done = 0;
        step(1, 0, '0, 1);
        for (int i = 0; i < 7; i++) step(0, 1, rnd_pix(), 1);
        step(1, 0, '0, 1);
        check("t4_wr_drop", wr_en, 0);
        n_writes = 0;
        for (int i = 0; i < TOTAL; i++) step(0, 1, rnd_pix(), 1);
        for (int i = 0; i < 8; i++) step(0, 0, '0, 1);
        check("t4_writes", n_writes, TOTAL);
        check("t4_done", n_done, 1);

        // Stray strobe while idle.
        step(0, 1, 12'hABC, 1);
        check("t5_serr", sync_err, 1);
        check("t5_no_wr", wr_en, 0);
        step(1, 0, '0, 1);
        check("t5_serr_clr", sync_err, 0);

        // Reset in the middle of a frame.
        for (int i = 0; i < 5; i++) step(0, 1, rnd_pix(), ($urandom_range(0, 1) != 0));
        #3 rst_n = 1'b0;
        #1;
        check_all_zero("t6_async");
        model_reset();
        sof = 0; strobe = 0; mem_ready = 1;
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        @(posedge clk);
        #1;
        n_writes = 0;
        for (int i = 0; i < 6; i++) step(0, 1, rnd_pix(), 1);
        check("t6_no_writes", n_writes, 0);
        check("t6_serr", sync_err, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
